kd_level_stage: RTL and testbench

KD_LEVEL_STAGE -- requirements
Module: kd_level_stage

---
 rtl/kd_level_stage_if.sv | 31 +++
 rtl/kd_level_stage.sv | 150 +++++++++++++++
 tb/tb_kd_level_stage.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/kd_level_stage_if.sv
// Query/result handshake bundle for one k-d tree level stage.
// The upstream side drives in_*, and the downstream side consumes out_*.
interface kd_level_stage_if #(
    parameter int COMP_WIDTH = 11,
    parameter int NUM_COMPS  = 5,
    parameter int LEVEL      = 1
);
    localparam int DATA_WIDTH = COMP_WIDTH * NUM_COMPS;
    localparam int NODE_W     = (LEVEL > 1) ? LEVEL : 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_patch;
    logic [NODE_W-1:0]     in_node;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_patch;
    logic [LEVEL:0]        out_node;
    logic                  out_dir;

    modport master (
        output in_valid, in_patch, in_node, out_ready,
        input  in_ready, out_valid, out_patch, out_node, out_dir
    );

    modport slave (
        input  in_valid, in_patch, in_node, out_ready,
        output in_ready, out_valid, out_patch, out_node, out_dir
    );
endinterface

// File: rtl/kd_level_stage.sv
// One level of a k-d tree descent pipeline: it compares one patch component against a stored median
// and registers the chosen child index behind a one-entry, full-throughput handshake slot.
module kd_level_stage #(
    parameter  int COMP_WIDTH    = 11,
    parameter  int NUM_COMPS     = 5,
    parameter  int LEVEL         = 1,
    localparam int DATA_WIDTH    = COMP_WIDTH * NUM_COMPS,
    localparam int NODE_W        = (LEVEL > 1) ? LEVEL : 1,
    localparam int IDX_WIDTH     = COMP_WIDTH,
    localparam int STORAGE_WIDTH = 2 * COMP_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wen_i,
    input  logic [NODE_W-1:0]        waddr_i,
    input  logic [STORAGE_WIDTH-1:0] wdata_i,
    kd_level_stage_if.slave          bus,
    output logic                     cfg_err_o
);

    localparam int NUM_NODES = 1 << LEVEL;
    localparam logic [IDX_WIDTH-1:0] COMP_LIMIT = IDX_WIDTH'(NUM_COMPS);

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_e;

    state_e                   state_q;
    logic [STORAGE_WIDTH-1:0] nodeMem_q [NUM_NODES];
    logic [DATA_WIDTH-1:0]    outPatch_q;
    logic [LEVEL:0]           outNode_q;
    logic                     outDir_q;
    logic                     cfgErr_q;

    logic [NUM_NODES-1:0]     wrSel;
    logic [NUM_NODES-1:0]     rdSel;
    logic [STORAGE_WIDTH-1:0] selWord;
    logic [IDX_WIDTH-1:0]     selIdx;
    logic [COMP_WIDTH-1:0]    selMedian;
    logic                     idxBad;
    logic [IDX_WIDTH-1:0]     effIdx;
    logic [COMP_WIDTH-1:0]    compSel;
    logic                     outDir_d;
    logic [LEVEL:0]           outNode_d;
    logic                     accept;

    // A single-node stage has no address bits, so both decoders collapse to the one node.
    generate
        if (LEVEL == 0) begin : g_single_node
            assign wrSel     = 1'b1;
            assign rdSel     = 1'b1;
            assign outNode_d = outDir_d;
        end else begin : g_multi_node
            assign wrSel     = NUM_NODES'(1) << waddr_i;
            assign rdSel     = NUM_NODES'(1) << bus.in_node;
            assign outNode_d = {bus.in_node[LEVEL-1:0], outDir_d};
        end
    endgenerate

    always_comb begin
        selWord = '0;
        for (int n = 0; n < NUM_NODES; n++) begin
            if (rdSel[n]) begin
                selWord = nodeMem_q[n];
            end
        end
    end

    assign selIdx    = selWord[IDX_WIDTH-1:0];
    assign selMedian = selWord[STORAGE_WIDTH-1:IDX_WIDTH];
    assign idxBad    = (selIdx >= COMP_LIMIT);
    assign effIdx    = idxBad ? '0 : selIdx;

    always_comb begin
        compSel = bus.in_patch[COMP_WIDTH-1:0];
        for (int k = 0; k < NUM_COMPS; k++) begin
            if (effIdx == IDX_WIDTH'(k)) begin
                compSel = bus.in_patch[k*COMP_WIDTH +: COMP_WIDTH];
            end
        end
    end

    // Ties go to the right child.
    assign outDir_d = (compSel < selMedian) ? 1'b0 : 1'b1;

    assign bus.in_ready  = (state_q == ST_EMPTY) || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_q == ST_FULL);
    assign bus.out_patch = outPatch_q;
    assign bus.out_node  = outNode_q;
    assign bus.out_dir   = outDir_q;
    assign cfg_err_o     = cfgErr_q;

    // The node read above happens before this edge's write lands, so a same-cycle query sees the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_NODES; n++) begin
                nodeMem_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_NODES; n++) begin
                if (wen_i && wrSel[n]) begin
                    nodeMem_q[n] <= wdata_i;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (!accept && bus.out_ready) begin
                        state_q <= ST_EMPTY;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outPatch_q <= '0;
            outNode_q  <= '0;
            outDir_q   <= 1'b0;
        end else if (accept) begin
            outPatch_q <= bus.in_patch;
            outNode_q  <= outNode_d;
            outDir_q   <= outDir_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfgErr_q <= 1'b0;
        end else if (accept && idxBad) begin
            cfgErr_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_kd_level_stage.sv
// Directed bench for kd_level_stage at LEVEL=1: it runs a vector table plus backpressure, streaming,
// same-cycle write/read, out-of-range index and reset sequences.
module tb_kd_level_stage;

    localparam int CW = 11;
    localparam int NC = 5;
    localparam int LV = 1;
    localparam int DW = CW * NC;

    typedef struct {
        logic [0:0]    node;
        logic [DW-1:0] patch;
        logic          expDir;
        logic [1:0]    expNode;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wen;
    logic [0:0]    waddr;
    logic [2*CW-1:0] wdata;
    logic          cfgErr;

    int testsRun  = 0;
    int failCount = 0;
    int hsCount   = 0;
    int hs0;

    logic [2*CW-1:0] tbNode [2];
    vec_t            vecs [9];
    logic [DW-1:0]   sp [8];
    logic [0:0]      sn [8];
    logic [DW-1:0]   pA, pB, pC, pD;
    logic            md;

    kd_level_stage_if #(.COMP_WIDTH(CW), .NUM_COMPS(NC), .LEVEL(LV)) bus ();

    kd_level_stage #(.COMP_WIDTH(CW), .NUM_COMPS(NC), .LEVEL(LV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wen_i     (wen),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .bus       (bus.slave),
        .cfg_err_o (cfgErr)
    );

    always #5 clk = ~clk;

    // Count completed output handshakes so lost or duplicated results show up.
    always @(posedge clk) begin
        if (bus.out_valid && bus.out_ready) hsCount++;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [0:0] node, input logic [DW-1:0] patch, input logic rdy);
        bus.in_valid  = v;
        bus.in_node   = node;
        bus.in_patch  = patch;
        bus.out_ready = rdy;
    endtask

    task automatic writeNode(input logic [0:0] a, input logic [2*CW-1:0] d);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        @(negedge clk);
        wen = 1'b0;
        tbNode[a] = d;
    endtask

    function automatic logic [DW-1:0] mkPatch(input logic [CW-1:0] c0, c1, c2, c3, c4);
        return {c4, c3, c2, c1, c0};
    endfunction

    function automatic logic modelDir(input logic [0:0] node, input logic [DW-1:0] patch);
        logic [CW-1:0] c, m, comp;
        int ci;
        c = tbNode[node][CW-1:0];
        m = tbNode[node][2*CW-1:CW];
        ci = (c >= CW'(NC)) ? 0 : int'(c);
        comp = patch[ci*CW +: CW];
        return (comp < m) ? 1'b0 : 1'b1;
    endfunction

    initial begin
        wen = 1'b0; waddr = 1'b0; wdata = '0;
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        tbNode[0] = '0; tbNode[1] = '0;

        #2;
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_cfg_err",   64'(cfgErr),        64'd0);
        checkOutput("rst_in_ready",  64'(bus.in_ready),  64'd1);
        checkOutput("rst_out_patch", 64'(bus.out_patch), 64'd0);
        checkOutput("rst_out_node",  64'(bus.out_node),  64'd0);
        checkOutput("rst_out_dir",   64'(bus.out_dir),   64'd0);
        @(negedge clk);
        @(negedge clk);

        // The first query is accepted on the first edge after release and sees the cleared node 0.
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("first_acc_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("first_acc_dir",   64'(bus.out_dir),   64'd1);
        checkOutput("first_acc_node",  64'(bus.out_node),  64'd1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);

        writeNode(1'b0, {11'd2, 11'd1});
        writeNode(1'b1, {11'd4, 11'd4});

        vecs[0] = '{1'b0, mkPatch(11'd3, 11'd1,    11'd3, 11'd3, 11'd3),   1'b0, 2'b00};
        vecs[1] = '{1'b0, mkPatch(11'd3, 11'd3,    11'd3, 11'd3, 11'd3),   1'b1, 2'b01};
        vecs[2] = '{1'b0, mkPatch(11'd0, 11'd2,    11'd0, 11'd0, 11'd0),   1'b1, 2'b01};
        vecs[3] = '{1'b1, mkPatch(11'd3, 11'd3,    11'd3, 11'd3, 11'd0),   1'b0, 2'b10};
        vecs[4] = '{1'b1, mkPatch(11'd3, 11'd3,    11'd3, 11'd3, 11'd512), 1'b1, 2'b11};
        vecs[5] = '{1'b1, mkPatch(11'd9, 11'd9,    11'd9, 11'd9, 11'd4),   1'b1, 2'b11};
        vecs[6] = '{1'b1, mkPatch(11'd0, 11'd0,    11'd0, 11'd0, 11'd3),   1'b0, 2'b10};
        vecs[7] = '{1'b0, mkPatch(11'd7, 11'd1,    11'd7, 11'd7, 11'd7),   1'b0, 2'b00};
        vecs[8] = '{1'b0, mkPatch(11'd0, 11'd2047, 11'd0, 11'd0, 11'd0),   1'b1, 2'b01};

        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, vecs[i].node, vecs[i].patch, 1'b1);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
            checkOutput($sformatf("vec%0d_dir", i),   64'(bus.out_dir),   64'(vecs[i].expDir));
            checkOutput($sformatf("vec%0d_node", i),  64'(bus.out_node),  64'(vecs[i].expNode));
            checkOutput($sformatf("vec%0d_patch", i), 64'(bus.out_patch), 64'(vecs[i].patch));
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("table_drain_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("table_cfg_err",     64'(cfgErr),        64'd0);

        // Backpressure: A is held for three cycles while B waits, then both emerge in order.
        pA = mkPatch(11'd1, 11'd2, 11'd3, 11'd4, 11'd5);
        pB = mkPatch(11'd5, 11'd6, 11'd7, 11'd8, 11'd1);
        hs0 = hsCount;
        applyStimulus(1'b1, 1'b0, pA, 1'b0);
        @(negedge clk);
        checkOutput("bp_a_valid", 64'(bus.out_valid), 64'd1);
        applyStimulus(1'b1, 1'b1, pB, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("bp_hold%0d_in_ready", k), 64'(bus.in_ready),  64'd0);
            checkOutput($sformatf("bp_hold%0d_patch", k),    64'(bus.out_patch), 64'(pA));
            checkOutput($sformatf("bp_hold%0d_dir", k),      64'(bus.out_dir),   64'd1);
            checkOutput($sformatf("bp_hold%0d_node", k),     64'(bus.out_node),  64'd1);
            @(negedge clk);
        end
        checkOutput("bp_no_early_hs", 64'(hsCount - hs0), 64'd0);
        applyStimulus(1'b1, 1'b1, pB, 1'b1);
        @(negedge clk);
        checkOutput("bp_b_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("bp_b_patch", 64'(bus.out_patch), 64'(pB));
        checkOutput("bp_b_dir",   64'(bus.out_dir),   64'd0);
        checkOutput("bp_b_node",  64'(bus.out_node),  64'd2);
        checkOutput("bp_hs_a",    64'(hsCount - hs0), 64'd1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("bp_drain_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("bp_hs_total",    64'(hsCount - hs0), 64'd2);

        // Streaming: eight back-to-back queries, each checked against the reference model.
        for (int i = 0; i < 8; i++) begin
            sp[i] = mkPatch(CW'(i * 3), CW'(i * 50), CW'(i), CW'(7 - i), (i == 3) ? 11'd2 : CW'(i * 100));
            sn[i] = 1'(i % 2);
        end
        hs0 = hsCount;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, sn[i], sp[i], 1'b1);
            @(negedge clk);
            md = modelDir(sn[i], sp[i]);
            checkOutput($sformatf("stream%0d_valid", i), 64'(bus.out_valid), 64'd1);
            checkOutput($sformatf("stream%0d_patch", i), 64'(bus.out_patch), 64'(sp[i]));
            checkOutput($sformatf("stream%0d_dir", i),   64'(bus.out_dir),   64'(md));
            checkOutput($sformatf("stream%0d_node", i),  64'(bus.out_node),  64'({sn[i], md}));
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("stream_hs_count", 64'(hsCount - hs0), 64'd8);
        checkOutput("stream_drain",    64'(bus.out_valid), 64'd0);

        // Write and accept on node 0 in the same cycle: old {2,1} sends comp1=5 right, new {9,1} sends it left.
        pC = mkPatch(11'd0, 11'd5, 11'd0, 11'd0, 11'd0);
        wen = 1'b1; waddr = 1'b0; wdata = {11'd9, 11'd1};
        applyStimulus(1'b1, 1'b0, pC, 1'b1);
        @(negedge clk);
        wen = 1'b0;
        tbNode[0] = {11'd9, 11'd1};
        checkOutput("samecyc_old_dir",  64'(bus.out_dir),  64'd1);
        checkOutput("samecyc_old_node", 64'(bus.out_node), 64'd1);
        @(negedge clk);
        checkOutput("samecyc_new_dir",  64'(bus.out_dir),  64'd0);
        checkOutput("samecyc_new_node", 64'(bus.out_node), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);

        // comp_idx 7 is out of range, so component 0 is used and the error flag latches.
        writeNode(1'b0, {11'd5, 11'd7});
        pD = mkPatch(11'd6, 11'd0, 11'd0, 11'd0, 11'd0);
        applyStimulus(1'b1, 1'b0, pD, 1'b1);
        @(negedge clk);
        checkOutput("cfg_dir",     64'(bus.out_dir),  64'd1);
        checkOutput("cfg_err_set", 64'(cfgErr),       64'd1);
        applyStimulus(1'b1, 1'b1, mkPatch(11'd0, 11'd0, 11'd0, 11'd0, 11'd9), 1'b1);
        @(negedge clk);
        checkOutput("cfg_err_sticky", 64'(cfgErr),       64'd1);
        checkOutput("cfg_q2_node",    64'(bus.out_node), 64'd3);
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        checkOutput("cfg_held_valid", 64'(bus.out_valid), 64'd1);

        // Reset while a result is held discards it at once; no handshake completes for it.
        hs0 = hsCount;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid",    64'(bus.out_valid), 64'd0);
        checkOutput("midrst_cfg_err",  64'(cfgErr),        64'd0);
        checkOutput("midrst_in_ready", 64'(bus.in_ready),  64'd1);
        checkOutput("midrst_patch",    64'(bus.out_patch), 64'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("midrst_no_hs", 64'(hsCount - hs0), 64'd0);
        rst_n = 1'b1;
        tbNode[0] = '0; tbNode[1] = '0;

        // Cleared nodes send all-zero patches right without raising the error flag.
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("postrst_n0_dir", 64'(bus.out_dir),  64'd1);
        checkOutput("postrst_n0_err", 64'(cfgErr),       64'd0);
        applyStimulus(1'b1, 1'b1, '0, 1'b1);
        @(negedge clk);
        checkOutput("postrst_n1_dir",  64'(bus.out_dir),  64'd1);
        checkOutput("postrst_n1_node", 64'(bus.out_node), 64'd3);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("final_drain", 64'(bus.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
